// File: rtl/ahb_bus_arbiter.sv
// Sixteen-master AHB bus arbiter with a registered one-hot grant and handover on HREADY.
// Define ROUND_ROBIN_EN for rotating priority; the default is fixed priority (master 0 highest).
module ahb_bus_arbiter (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [15:0] HBUSREQx,
    input  logic [15:0] HLOCKx,
    output logic [15:0] HGRANTx,
    input  logic [15:0] HSPLIT,
    input  logic        HREADY,
    output logic [3:0]  HMASTER,
    output logic        HMASTLOCK
);

    logic [15:0] eligible;
    logic [15:0] sel_onehot;
    logic [3:0]  grant_idx;

    // A locked owner that is still requesting keeps the bus, even if it is split-masked.
    always_comb begin
        eligible = HBUSREQx & ~HSPLIT;
        if (HMASTLOCK && HBUSREQx[HMASTER]) begin
            eligible          = '0;
            eligible[HMASTER] = 1'b1;
        end
    end

`ifdef ROUND_ROBIN_EN
    // Search starts just above the current owner; 4-bit arithmetic wraps 15 -> 0.
    always_comb begin
        logic       found;
        logic [3:0] idx;
        sel_onehot = '0;
        found      = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            idx = HMASTER + 4'(i) + 4'd1;
            if (!found && eligible[idx]) begin
                sel_onehot[idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        sel_onehot = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (!found && eligible[i]) begin
                sel_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (HGRANTx[i]) begin
                grant_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HGRANTx   <= '0;
            HMASTER   <= '0;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            HGRANTx <= '0;
            if (HGRANTx != '0) begin
                HMASTER   <= grant_idx;
                HMASTLOCK <= HLOCKx[grant_idx];
            end
        end else if (HGRANTx == '0) begin
            HGRANTx <= sel_onehot;
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed vector table plus reset and random-invariant sequences for ahb_bus_arbiter.
module tb_ahb_bus_arbiter;

    logic        HCLK;
    logic        HRESET;
    logic [15:0] HBUSREQx;
    logic [15:0] HLOCKx;
    logic [15:0] HGRANTx;
    logic [15:0] HSPLIT;
    logic        HREADY;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;

    int unsigned n_checks;
    int unsigned n_fails;

    ahb_bus_arbiter dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQx  (HBUSREQx),
        .HLOCKx    (HLOCKx),
        .HGRANTx   (HGRANTx),
        .HSPLIT    (HSPLIT),
        .HREADY    (HREADY),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [15:0] req;
        logic [15:0] lock;
        logic [15:0] split;
        logic        ready;
        logic [15:0] grant;
        logic [3:0]  master;
        logic        mlock;
    } vec_t;

`ifdef ROUND_ROBIN_EN
    localparam logic [15:0] G5  = 16'h8000;
    localparam logic [3:0]  M6  = 4'd15;
    localparam logic [15:0] G9  = 16'h0004;
    localparam logic [3:0]  M10 = 4'd2;
`else
    localparam logic [15:0] G5  = 16'h0002;
    localparam logic [3:0]  M6  = 4'd1;
    localparam logic [15:0] G9  = 16'h0002;
    localparam logic [3:0]  M10 = 4'd1;
`endif

    vec_t vecs [26];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, " grant"},  HGRANTx, 16'h0000);
        check({name, " master"}, {12'h0, HMASTER}, 16'h0000);
        check({name, " lock"},   {15'h0, HMASTLOCK}, 16'h0000);
    endtask

    initial begin
        //                req       lock      split     rdy   grant     mst    ml
        vecs[0]  = '{16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h0020, 4'd0,  1'b0}; // single request granted
        vecs[1]  = '{16'h0020, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd5,  1'b0}; // handover to 5
        vecs[2]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd5,  1'b0}; // parked
        vecs[3]  = '{16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd5,  1'b0};
        vecs[4]  = '{16'h8006, 16'h0000, 16'h0000, 1'b0, G5,       4'd5,  1'b0};
        vecs[5]  = '{16'h8006, 16'h0000, 16'h0000, 1'b1, 16'h0000, M6,    1'b0};
        vecs[6]  = '{16'h8006, 16'h0000, 16'h0000, 1'b0, 16'h0002, M6,    1'b0};
        vecs[7]  = '{16'h8006, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd1,  1'b0}; // owner now 1
        vecs[8]  = '{16'h8006, 16'h0000, 16'h0000, 1'b0, G9,       4'd1,  1'b0}; // priority from owner 1
        vecs[9]  = '{16'h8006, 16'h0000, 16'h0000, 1'b1, 16'h0000, M10,   1'b0};
        vecs[10] = '{16'h0010, 16'h0000, 16'h0000, 1'b1, 16'h0000, M10,   1'b0}; // clear wins over new req
        vecs[11] = '{16'h0003, 16'h0000, 16'h0001, 1'b0, 16'h0002, M10,   1'b0}; // split masks 0
        vecs[12] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0002, M10,   1'b0}; // grant held after drop
        vecs[13] = '{16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd1,  1'b0};
        vecs[14] = '{16'h0003, 16'h0000, 16'h0003, 1'b0, 16'h0000, 4'd1,  1'b0}; // all split
        vecs[15] = '{16'h0003, 16'h0000, 16'h0003, 1'b0, 16'h0000, 4'd1,  1'b0};
        vecs[16] = '{16'h0008, 16'h0008, 16'h0000, 1'b0, 16'h0008, 4'd1,  1'b0};
        vecs[17] = '{16'h0008, 16'h0008, 16'h0000, 1'b1, 16'h0000, 4'd3,  1'b1}; // locked owner 3
        vecs[18] = '{16'h0009, 16'h0008, 16'h0008, 1'b0, 16'h0008, 4'd3,  1'b1}; // lock overrides split
        vecs[19] = '{16'h0009, 16'h0008, 16'h0000, 1'b1, 16'h0000, 4'd3,  1'b1};
        vecs[20] = '{16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0001, 4'd3,  1'b1}; // lock released by drop
        vecs[21] = '{16'h0001, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0};
        vecs[22] = '{16'h0004, 16'h0000, 16'h0000, 1'b0, 16'h0004, 4'd0,  1'b0};
        vecs[23] = '{16'h0004, 16'h0000, 16'h0004, 1'b0, 16'h0004, 4'd0,  1'b0}; // split never revokes
        vecs[24] = '{16'h0004, 16'h0000, 16'h0004, 1'b1, 16'h0000, 4'd2,  1'b0};
        vecs[25] = '{16'h0002, 16'h0000, 16'h0000, 1'b0, 16'h0002, 4'd2,  1'b0};
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        HRESET   = 1'b0;
        HBUSREQx = 16'hFFFF;
        HLOCKx   = 16'hFFFF;
        HSPLIT   = '0;
        HREADY   = 1'b0;

        // Asynchronous reset assertion between edges with requests active.
        #2;
        HRESET = 1'b1;
        #1;
        check_reset_state("async reset");
        @(posedge HCLK);
        @(negedge HCLK);
        HRESET   = 1'b0;
        HBUSREQx = '0;
        HLOCKx   = '0;

        for (int i = 0; i < 26; i++) begin
            @(negedge HCLK);
            HBUSREQx = vecs[i].req;
            HLOCKx   = vecs[i].lock;
            HSPLIT   = vecs[i].split;
            HREADY   = vecs[i].ready;
            @(posedge HCLK);
            #1;
            check($sformatf("vec%0d grant", i),  HGRANTx, vecs[i].grant);
            check($sformatf("vec%0d master", i), {12'h0, HMASTER}, {12'h0, vecs[i].master});
            check($sformatf("vec%0d lock", i),   {15'h0, HMASTLOCK}, {15'h0, vecs[i].mlock});
        end

        // Reset mid-sequence drops the pending grant 0x0002 and the owner 2.
        #2;
        HRESET = 1'b1;
        #1;
        check_reset_state("mid reset");
        @(negedge HCLK);
        HRESET = 1'b0;
        HREADY = 1'b0;
        HBUSREQx = 16'h0040;
        HSPLIT = '0;
        HLOCKx = '0;
        @(posedge HCLK);
        #1;
        check("post reset grant", HGRANTx, 16'h0040);

        // Random traffic: grant never multi-hot and always cleared by an HREADY edge.
        for (int c = 0; c < 10000; c++) begin
            logic rdy;
            @(negedge HCLK);
            HBUSREQx = 16'($urandom);
            HLOCKx   = 16'($urandom);
            HSPLIT   = 16'($urandom) & 16'($urandom);
            rdy      = 1'($urandom_range(0, 1));
            HREADY   = rdy;
            @(posedge HCLK);
            #1;
            check("onehot", {11'h0, 5'($countones(HGRANTx))} <= 16'd1 ? 16'd0 : HGRANTx, 16'd0);
            if (rdy) begin
                check("ready clears grant", HGRANTx, 16'h0000);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Sixteen-master AHB bus arbiter. Samples per-master bus requests, lock and split-mask inputs, and issues a one-hot registered grant. Hands bus ownership (HMASTER/HMASTLOCK) over at the completion of the current transfer. Sits between the master request lines and the address/control multiplexer of the AHB interconnect.

## Interface
- No parameters (master count fixed at 16, master index 4 bits).
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HBUSREQx  in  16  bus request, bit i = master i.
- HLOCKx  in  16  locked-transfer request, bit i = master i.
- HGRANTx  out  16  registered grant, at most one bit set.
- HSPLIT  in  16  split mask; bit i = 1 makes master i ineligible for arbitration.
- HREADY  in  1  transfer-complete indication from the slave side.
- HMASTER  out  4  index of the master owning the address bus.
- HMASTLOCK  out  1  current owner is performing a locked sequence.

## Operation
- Eligible set E = HBUSREQx & ~HSPLIT.
- Lock rule: if HMASTLOCK = 1 and HBUSREQx[HMASTER] = 1, E is restricted to bit HMASTER, regardless of HSPLIT.
- Selection: fixed priority, lowest index wins (see Configuration for round-robin).
- Per rising edge, grant register:
  - HREADY = 1: HGRANTx <= 0 (handover edge). If HGRANTx was nonzero, HMASTER <= index of its set bit and HMASTLOCK <= HLOCKx[that index].
  - HREADY = 0 and HGRANTx = 0: HGRANTx <= one-hot of selected master in E, or 0 if E empty.
  - HREADY = 0 and HGRANTx != 0: grant held unchanged, even if the request drops.
- HMASTER and HMASTLOCK change only on handover edges; otherwise they hold. With no requests the last owner is parked.
- HGRANTx is never multi-hot. Invariant: after any edge with HREADY = 1, HGRANTx = 0.

## Timing
- Reset values: HGRANTx = 16'h0000, HMASTER = 4'h0, HMASTLOCK = 0. Asynchronous assertion; the first arbitration happens on the first edge after release.
- Grant latency: request present at an edge with HREADY = 0 and no grant outstanding gives HGRANTx set immediately after that edge (1 cycle).
- Ownership latency: HMASTER updates on the first subsequent edge with HREADY = 1. On that same edge HGRANTx clears.
- HREADY = 1 and new request on the same edge: the clear wins. Arbitration happens on the next HREADY = 0 edge.
- HSPLIT change takes effect at the next arbitration edge. A grant already issued is not revoked.
- Reset mid-sequence: all outputs return to reset values immediately; the pending grant is lost.

## Configuration
- ROUND_ROBIN_EN defined: selection searches E starting at HMASTER+1, modulo 16, wrapping 15→0. The first set bit wins. The lock rule still overrides.
- ROUND_ROBIN_EN undefined: fixed priority, master 0 highest, master 15 lowest.

## Test plan
- Reset: assert HRESET with requests active → HGRANTx = 0, HMASTER = 0, HMASTLOCK = 0 asynchronously.
- Single request: HBUSREQx = 16'h0020, HREADY = 0 for one edge → HGRANTx = 16'h0020. Then HREADY = 1 for one edge → HGRANTx = 0, HMASTER = 5.
- Priority: HBUSREQx = 16'h8006, HREADY = 0 → HGRANTx = 16'h0002 without ROUND_ROBIN_EN. With ROUND_ROBIN_EN and HMASTER = 1 → HGRANTx = 16'h0004.
- Split mask: HBUSREQx = 16'h0003, HSPLIT = 16'h0001 → HGRANTx = 16'h0002. With HSPLIT = 16'h0003 → HGRANTx stays 0.
- Lock: master 3 owns with HLOCKx[3] = 1 (HMASTLOCK = 1), HBUSREQx = 16'h0009 → regrant HGRANTx = 16'h0008, HMASTER stays 3.
- Invariants over 10k random cycles: countones(HGRANTx) ≤ 1 every cycle, and HREADY = 1 at edge n implies HGRANTx = 0 after edge n.
